// File: rtl/ch_pack_pkg.sv
// Shared constants and state encoding for the channel packer.
// Imported by ch_snap_mux and ch_pack.
package ch_pack_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;
  localparam int SEL_W    = 3;
  localparam int NCH_MAX  = 8;

  localparam logic [SAMPLE_W-1:0] PAD_HALF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/ch_snap_mux.sv
// Snapshot register for all channel samples plus the read mux by sel.
// Ports: clk, reset, load (strobe), ch_data in; sel in; sample out (0 if sel >= NCH).
module ch_snap_mux
  import ch_pack_pkg::*;
#(
  parameter int NCH = NCH_MAX,
  parameter int DW  = SAMPLE_W,
  parameter int SW  = SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [SW-1:0]     sel,
  output logic [DW-1:0]     sample
);

  logic [NCH*DW-1:0] snap_q;
  logic [NCH*DW-1:0] snap_d;

  always_comb begin
    snap_d = snap_q;
    if (load) snap_d = ch_data;
  end

  always_ff @(posedge clk) begin
    if (reset) snap_q <= '0;
    else       snap_q <= snap_d;
  end

  // Reads the old snapshot, so a load and a read in
  // the same cycle see the pre-load value.
  always_comb begin
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SW'(k)) sample = snap_q[k*DW +: DW];
    end
  end

endmodule

// File: rtl/ch_pack.sv
// Packs pairs of selected channel samples into 2*DW words for the host FIFO.
// Ports: clk, reset, strobe, en, sel, ch_data, fifo_full, clear_status in;
//        fifo_wr, fifo_data, overrun, frame_err out.
module ch_pack
  import ch_pack_pkg::*;
#(
  parameter int NCH = NCH_MAX,
  parameter int DW  = SAMPLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe,
  input  logic              en,
  input  logic [SEL_W-1:0]  sel,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [2*DW-1:0]   fifo_data,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clear_status
);

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic            wr_q, wr_d;
  logic [2*DW-1:0] data_q, data_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;

  logic [DW-1:0]   sample;
  logic            abort;
  logic            consume;
  logic            due;
  logic [2*DW-1:0] word;

  ch_snap_mux #(
    .NCH (NCH),
    .DW  (DW),
    .SW  (SEL_W)
  ) u_snap (
    .clk     (clk),
    .reset   (reset),
    .load    (strobe),
    .ch_data (ch_data),
    .sel     (sel),
    .sample  (sample)
  );

  // A strobe inside a frame kills it; en is ignored
  // during FLUSH and in the aborting cycle.
  assign abort   = strobe && (state_q != IDLE);
  assign consume = en && !abort && (state_q != FLUSH);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    lo_d    = lo_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    ovr_d   = ovr_q && !clear_status;
    ferr_d  = ferr_q && !clear_status;
    due     = 1'b0;
    word    = '0;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!en) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = IDLE;
        if (pend_q && !abort) begin
          due    = 1'b1;
          word   = {DW'(PAD_HALF), lo_q};
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      if (!pend_q) begin
        lo_d   = sample;
        pend_d = 1'b1;
      end else begin
        due    = 1'b1;
        word   = {sample, lo_q};
        pend_d = 1'b0;
      end
    end

    if (abort) begin
      ferr_d  = 1'b1;
      pend_d  = 1'b0;
      state_d = IDLE;
    end

    if (due) begin
      if (fifo_full) begin
        ovr_d = 1'b1;
      end else begin
        wr_d   = 1'b1;
        data_d = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      lo_q    <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign fifo_wr   = wr_q;
  assign fifo_data = data_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_ch_pack.sv
// Directed bench for ch_pack with a scoreboard of expected FIFO words.
// Monitor compares every fifo_wr against the queue head.
module tb_ch_pack;

  localparam int NCH = 8;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              strobe;
  logic              en;
  logic [2:0]        sel;
  logic [NCH*DW-1:0] ch_data;
  logic              fifo_full;
  logic              fifo_wr;
  logic [2*DW-1:0]   fifo_data;
  logic              overrun;
  logic              frame_err;
  logic              clear_status;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [15:0] chv[NCH];
  logic prev_wr = 1'b0;

  ch_pack dut (
    .clk          (clk),
    .reset        (reset),
    .strobe       (strobe),
    .en           (en),
    .sel          (sel),
    .ch_data      (ch_data),
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_data    (fifo_data),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .clear_status (clear_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NCH*DW-1:0] pack_ch();
    logic [NCH*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = chv[k];
    return v;
  endfunction

  task automatic set_ch(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    for (int k = 0; k < NCH; k++) chv[k] = 16'h0;
    chv[0] = a;
    chv[1] = b;
    chv[2] = c;
    chv[3] = d;
  endtask

  task automatic run_frame(input int n, input bit scramble);
    for (int i = 0; i < n; i += 2) begin
      logic [15:0] hi;
      hi = (i + 1 < n) ? chv[i+1] : 16'h0000;
      sb.push_back({hi, chv[i]});
    end
    ch_data = pack_ch();
    strobe  = 1'b1;
    tick();
    strobe = 1'b0;
    if (scramble) ch_data = '1;
    for (int i = 0; i < n; i++) begin
      en  = 1'b1;
      sel = 3'(i);
      tick();
    end
    en = 1'b0;
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    if (!reset && fifo_wr) begin
      if (sb.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
      else check("word", fifo_data, sb.pop_front());
      check("wr_back_to_back", {31'd0, prev_wr}, 32'd0);
    end
    prev_wr = fifo_wr;
  end

  initial begin
    reset = 1'b1;
    strobe = 1'b0;
    en = 1'b0;
    sel = '0;
    ch_data = '0;
    fifo_full = 1'b0;
    clear_status = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_wr", {31'd0, fifo_wr}, 32'd0);
    check("rst_data", fifo_data, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    tick();

    set_ch(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_frame(4, 1'b0);
    check("f4_ovr", {31'd0, overrun}, 32'd0);
    check("f4_ferr", {31'd0, frame_err}, 32'd0);

    run_frame(3, 1'b0);
    check("f3_flags", {30'd0, overrun, frame_err}, 32'd0);

    set_ch(16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    run_frame(4, 1'b1);

    for (int k = 0; k < NCH; k++) chv[k] = 16'(16'h0a00 + k);
    run_frame(8, 1'b0);
    run_frame(1, 1'b0);

    set_ch(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    sb.push_back(32'h2222_1111);
    ch_data = pack_ch();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      sel = 3'(i);
      fifo_full = (i == 3);
      tick();
    end
    en = 1'b0;
    tick();
    fifo_full = 1'b0;
    repeat (2) tick();
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_ferr", {31'd0, frame_err}, 32'd0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 32'd0);

    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    en = 1'b1;
    sel = 3'd0;
    tick();
    sel = 3'd1;
    fifo_full = 1'b1;
    clear_status = 1'b1;
    tick();
    en = 1'b0;
    fifo_full = 1'b0;
    clear_status = 1'b0;
    repeat (2) tick();
    check("ovr_set_wins", {31'd0, overrun}, 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;

    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    en = 1'b1;
    sel = 3'd0;
    tick();
    en = 1'b0;
    set_ch(16'haaaa, 16'hbbbb, 16'h0, 16'h0);
    ch_data = pack_ch();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (2) tick();
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_nowr", sb.size(), 32'd0);
    sb.push_back(32'hbbbb_aaaa);
    en = 1'b1;
    sel = 3'd0;
    tick();
    sel = 3'd1;
    tick();
    en = 1'b0;
    repeat (3) tick();
    check("ferr_sticky", {31'd0, frame_err}, 32'd1);

    set_ch(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    ch_data = pack_ch();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    en = 1'b1;
    sel = 3'd0;
    tick();
    reset = 1'b1;
    sel = 3'd1;
    tick();
    @(negedge clk);
    check("rst_mid_wr", {31'd0, fifo_wr}, 32'd0);
    check("rst_mid_data", fifo_data, 32'd0);
    check("rst_mid_flags", {30'd0, overrun, frame_err}, 32'd0);
    reset = 1'b0;
    en = 1'b0;
    repeat (3) tick();

    set_ch(16'hcafe, 16'hbeef, 16'h0123, 16'h4567);
    run_frame(4, 1'b0);
    check("post_rst_flags", {30'd0, overrun, frame_err}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
